// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and memory-side bus of the load/store sequencer.
// The controller uses the slave view; the core/memory environment uses master.
interface lsu_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 14
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [2:0]              req_funct3;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [31:0]             req_wdata;
   logic                    resp_valid;
   logic                    resp_err;
   logic [31:0]             resp_rdata;
   logic                    busy;
   logic [ADDR_WIDTH-3:0]   mem_addr;
   logic                    mem_we;
   logic                    mem_re;
   logic [3:0]              mem_byte_sel;
   logic [31:0]             mem_wdata;
   logic [31:0]             mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, busy,
             mem_addr, mem_we, mem_re, mem_byte_sel, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, busy,
             mem_addr, mem_we, mem_re, mem_byte_sel, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: byte-lane steering, misaligned splitting into two word
// accesses, and alignment/extension of returned load data.
module lsu_mem_ctrl #(
   parameter int ADDR_WIDTH       = 14,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   lsu_mem_ctrl_if.slave bus
);
   localparam int WW = ADDR_WIDTH - 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      CAP0 = 3'd2,
      ACC1 = 3'd3,
      CAP1 = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_e;

   state_e         state_q, state_d;

   logic           we_q;
   logic [2:0]     f3_q;
   logic [1:0]     off_q;
   logic           mis_q;
   logic [WW-1:0]  word_q;
   logic [3:0]     sel_hi_q;
   logic [31:0]    wdata_hi_q;
   logic [31:0]    lo_q, hi_q;

   logic [WW-1:0]  mem_addr_q, mem_addr_d;
   logic           mem_we_q, mem_we_d;
   logic           mem_re_q, mem_re_d;
   logic [3:0]     mem_sel_q, mem_sel_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic           resp_valid_q, resp_valid_d;
   logic           resp_err_q, resp_err_d;
   logic [31:0]    resp_rdata_q, resp_rdata_d;

   logic [1:0]     req_off_s;
   logic [WW-1:0]  req_word_s;
   logic [3:0]     req_mask_s;
   logic [7:0]     req_sel8_s;
   logic [63:0]    req_wide_s;
   logic           req_illegal_s;
   logic           req_mis_s;
   logic           accept_s;

   // Shift the {hi,lo} pair down by the byte offset, then mask and extend by size.
   function automatic logic [31:0] align_load(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] off, input logic [2:0] f3);
      logic [63:0] cat;
      logic [31:0] raw;
      cat = {hi, lo} >> {off, 3'b000};
      raw = cat[31:0];
      case (f3)
         3'b000:  align_load = {{24{raw[7]}}, raw[7:0]};
         3'b001:  align_load = {{16{raw[15]}}, raw[15:0]};
         3'b010:  align_load = raw;
         3'b100:  align_load = {24'h000000, raw[7:0]};
         3'b101:  align_load = {16'h0000, raw[15:0]};
         default: align_load = 32'h0000_0000;
      endcase
   endfunction

   assign req_off_s  = bus.req_addr[1:0];
   assign req_word_s = bus.req_addr[ADDR_WIDTH-1:2];
   assign req_sel8_s = {4'b0000, req_mask_s} << req_off_s;
   assign req_wide_s = {32'h0000_0000, bus.req_wdata} << {req_off_s, 3'b000};
   assign req_mis_s  = |req_sel8_s[7:4];
   assign accept_s   = bus.req_valid && (state_q == IDLE);
   assign req_illegal_s = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                          (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);

   // Size mask from the low funct3 bits.
   always_comb begin
      req_mask_s = 4'b0000;
      case (bus.req_funct3[1:0])
         2'b00:   req_mask_s = 4'b0001;
         2'b01:   req_mask_s = 4'b0011;
         2'b10:   req_mask_s = 4'b1111;
         default: req_mask_s = 4'b0000;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (req_illegal_s || (req_mis_s && !ALLOW_MISALIGNED)) state_d = ERR;
               else                                                   state_d = ACC0;
            end else begin
               state_d = IDLE;
            end
         end
         ACC0:    state_d = we_q ? (mis_q ? ACC1 : DONE) : CAP0;
         CAP0:    state_d = mis_q ? ACC1 : DONE;
         ACC1:    state_d = we_q ? DONE : CAP1;
         CAP1:    state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; memory strobes lead the ACC states.
   always_comb begin
      mem_addr_d   = '0;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      mem_sel_d    = 4'b0000;
      mem_wdata_d  = 32'h0000_0000;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0000_0000;
      if (state_d == ACC0) begin
         mem_addr_d  = req_word_s;
         mem_sel_d   = req_sel8_s[3:0];
         mem_we_d    = bus.req_we;
         mem_re_d    = !bus.req_we;
         mem_wdata_d = bus.req_we ? req_wide_s[31:0] : 32'h0000_0000;
      end else if (state_d == ACC1) begin
         mem_addr_d  = word_q + {{(WW-1){1'b0}}, 1'b1};
         mem_sel_d   = sel_hi_q;
         mem_we_d    = we_q;
         mem_re_d    = !we_q;
         mem_wdata_d = we_q ? wdata_hi_q : 32'h0000_0000;
      end else begin
         mem_we_d = 1'b0;
      end
      if (state_q == DONE) begin
         resp_valid_d = 1'b1;
         resp_rdata_d = we_q ? 32'h0000_0000 : align_load(lo_q, hi_q, off_q, f3_q);
      end else if (state_q == ERR) begin
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b1;
      end else begin
         resp_valid_d = 1'b0;
      end
   end

   // Request latch and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         mis_q      <= 1'b0;
         word_q     <= '0;
         sel_hi_q   <= 4'b0000;
         wdata_hi_q <= 32'h0000_0000;
         lo_q       <= 32'h0000_0000;
         hi_q       <= 32'h0000_0000;
      end else if (accept_s) begin
         we_q       <= bus.req_we;
         f3_q       <= bus.req_funct3;
         off_q      <= req_off_s;
         mis_q      <= req_mis_s;
         word_q     <= req_word_s;
         sel_hi_q   <= req_sel8_s[7:4];
         wdata_hi_q <= req_wide_s[63:32];
         hi_q       <= 32'h0000_0000;
      end else if (state_q == CAP0) begin
         lo_q <= bus.mem_rdata;
      end else if (state_q == CAP1) begin
         hi_q <= bus.mem_rdata;
      end else begin
         lo_q <= lo_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_sel_q    <= 4'b0000;
         mem_wdata_q  <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
      end else begin
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         mem_sel_q    <= mem_sel_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_re       = mem_re_q;
   assign bus.mem_byte_sel = mem_sel_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.resp_rdata   = resp_rdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a byte-lane memory model plus hand-computed
// expectations for lane steering, splitting, wrap, extension, errors and reset.
module tb_lsu_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if #(.ADDR_WIDTH(14)) bus_a ();
   lsu_mem_ctrl_if #(.ADDR_WIDTH(14)) bus_b ();

   lsu_mem_ctrl #(.ADDR_WIDTH(14), .ALLOW_MISALIGNED(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );
   lsu_mem_ctrl #(.ADDR_WIDTH(14), .ALLOW_MISALIGNED(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   logic [31:0] mem [0:4095];
   logic [11:0] log_addr  [0:63];
   logic [3:0]  log_sel   [0:63];
   logic [31:0] log_wdata [0:63];
   logic        log_we    [0:63];
   int          acc_cnt = 0;
   int          b_acc   = 0;

   assign bus_b.mem_rdata = 32'h0000_0000;

   // Byte-lane memory with one-cycle read latency, plus an access log.
   always @(posedge clk) begin
      if (bus_a.mem_we) begin
         for (int i = 0; i < 4; i++)
            if (bus_a.mem_byte_sel[i]) mem[bus_a.mem_addr][8*i +: 8] <= bus_a.mem_wdata[8*i +: 8];
      end
      if (bus_a.mem_re) bus_a.mem_rdata <= mem[bus_a.mem_addr];
      if (bus_a.mem_we || bus_a.mem_re) begin
         log_addr[acc_cnt % 64]  <= bus_a.mem_addr;
         log_sel[acc_cnt % 64]   <= bus_a.mem_byte_sel;
         log_wdata[acc_cnt % 64] <= bus_a.mem_wdata;
         log_we[acc_cnt % 64]    <= bus_a.mem_we;
         acc_cnt <= acc_cnt + 1;
      end
      if (bus_b.mem_we || bus_b.mem_re) b_acc <= b_acc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outs(input string tag);
      check(tag, {bus_a.req_ready, bus_a.busy, bus_a.resp_valid, bus_a.resp_err,
                  bus_a.mem_we, bus_a.mem_re, bus_a.mem_byte_sel, 20'(bus_a.mem_addr)},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 20'h00000});
      check({tag, "_data"}, bus_a.mem_wdata | bus_a.resp_rdata, 32'h0000_0000);
   endtask

   task automatic run_a(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                        input logic [31:0] wdata, output int base, output int lat,
                        output logic [31:0] rdata, output logic err);
      logic got;
      base = acc_cnt;
      got = 1'b0;
      lat = 0;
      rdata = 32'hxxxx_xxxx;
      err = 1'bx;
      @(negedge clk);
      bus_a.req_valid = 1'b1;
      bus_a.req_we = we;
      bus_a.req_funct3 = f3;
      bus_a.req_addr = addr;
      bus_a.req_wdata = wdata;
      @(posedge clk);
      #1 bus_a.req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (!got) begin
            if (c > 1) @(posedge clk);
            else @(posedge clk);
            #1;
            if (bus_a.resp_valid) begin
               got = 1'b1;
               lat = c;
               rdata = bus_a.resp_rdata;
               err = bus_a.resp_err;
            end
         end
      end
      if (!got) check("resp_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   int          base, lat, nresp;
   logic [31:0] rd;
   logic        er;

   initial begin
      bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'b000;
      bus_a.req_addr = 14'h0000; bus_a.req_wdata = 32'h0000_0000;
      bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_funct3 = 3'b000;
      bus_b.req_addr = 14'h0000; bus_b.req_wdata = 32'h0000_0000;
      #1 check_idle_outs("reset");
      #20 rst_n = 1'b1;
      @(negedge clk);

      run_a(1'b1, 3'b010, 14'h0010, 32'hDEADBEEF, base, lat, rd, er);
      check("sw_naccess", acc_cnt - base, 32'd1);
      check("sw_access", {20'(log_addr[base]), 4'(log_sel[base]), 8'(log_we[base])},
            {20'h00004, 4'b1111, 8'h01});
      check("sw_wdata", log_wdata[base], 32'hDEADBEEF);
      check("sw_lat", lat, 32'd2);
      check("sw_resp", {rd[30:0], er}, 32'h0000_0000);

      run_a(1'b0, 3'b010, 14'h0010, 32'h0, base, lat, rd, er);
      check("lw_rdata", rd, 32'hDEADBEEF);
      check("lw_lat", lat, 32'd3);
      check("lw_access", {20'(log_addr[base]), 4'(log_sel[base]), 8'(log_we[base])},
            {20'h00004, 4'b1111, 8'h00});

      run_a(1'b1, 3'b000, 14'h0023, 32'h0000_0080, base, lat, rd, er);
      check("sb_access", {20'(log_addr[base]), 4'(log_sel[base]), 8'(log_we[base])},
            {20'h00008, 4'b1000, 8'h01});
      check("sb_wdata_hi", {24'h0, log_wdata[base][31:24]}, 32'h0000_0080);
      run_a(1'b0, 3'b000, 14'h0023, 32'h0, base, lat, rd, er);
      check("lb_rdata", rd, 32'hFFFFFF80);
      run_a(1'b0, 3'b100, 14'h0023, 32'h0, base, lat, rd, er);
      check("lbu_rdata", rd, 32'h0000_0080);

      run_a(1'b1, 3'b010, 14'h0006, 32'h11223344, base, lat, rd, er);
      check("msw_naccess", acc_cnt - base, 32'd2);
      check("msw_acc0", {20'(log_addr[base]), 4'(log_sel[base]), 8'(log_we[base])},
            {20'h00001, 4'b1100, 8'h01});
      check("msw_wdata0", log_wdata[base], 32'h33440000);
      check("msw_acc1", {20'(log_addr[base+1]), 4'(log_sel[base+1]), 8'(log_we[base+1])},
            {20'h00002, 4'b0011, 8'h01});
      check("msw_wdata1", log_wdata[base+1], 32'h00001122);
      check("msw_lat", lat, 32'd3);
      run_a(1'b0, 3'b010, 14'h0006, 32'h0, base, lat, rd, er);
      check("mlw_rdata", rd, 32'h11223344);
      check("mlw_lat", lat, 32'd5);

      run_a(1'b1, 3'b000, 14'h3FFF, 32'h0000_0012, base, lat, rd, er);
      run_a(1'b1, 3'b000, 14'h0000, 32'h0000_0085, base, lat, rd, er);
      run_a(1'b0, 3'b001, 14'h3FFF, 32'h0, base, lat, rd, er);
      check("lh_wrap_acc0", {20'(log_addr[base]), 4'(log_sel[base]), 8'h0},
            {20'h00FFF, 4'b1000, 8'h00});
      check("lh_wrap_acc1", {20'(log_addr[base+1]), 4'(log_sel[base+1]), 8'h0},
            {20'h00000, 4'b0001, 8'h00});
      check("lh_wrap_rdata", rd, 32'hFFFF8512);
      run_a(1'b0, 3'b101, 14'h3FFF, 32'h0, base, lat, rd, er);
      check("lhu_wrap_rdata", rd, 32'h0000_8512);

      run_a(1'b0, 3'b011, 14'h0010, 32'h0, base, lat, rd, er);
      check("err_f3_lat", lat, 32'd1);
      check("err_f3_resp", {rd[30:0], er}, 32'h0000_0001);
      check("err_f3_noacc", acc_cnt - base, 32'd0);
      run_a(1'b1, 3'b100, 14'h0010, 32'h0, base, lat, rd, er);
      check("err_sbu", {lat[30:0], er}, {31'd1, 1'b1});

      // Misalignment rejected on the instance that does not split.
      bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0;
      bus_b.req_funct3 = 3'b010; bus_b.req_addr = 14'h0001;
      @(posedge clk);
      #1 bus_b.req_valid = 1'b0;
      @(posedge clk);
      #1 check("nomis_resp", {29'h0, bus_b.resp_valid, bus_b.resp_err, |bus_b.resp_rdata},
               {29'h0, 1'b1, 1'b1, 1'b0});
      check("nomis_noacc", b_acc, 32'd0);

      // Reset in the middle of a split load.
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0;
      bus_a.req_funct3 = 3'b010; bus_a.req_addr = 14'h0006;
      @(posedge clk);
      #1 bus_a.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_idle_outs("midop_reset");
      @(negedge clk) rst_n = 1'b1;
      nresp = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1 if (bus_a.resp_valid) nresp++;
      end
      check("midop_no_resp", nresp, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the core's MEM stage and the four-lane byte-banked data memory.
- Accepts one byte-addressed RISC-V load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) per handshake.
- Produces word address, per-lane byte select, lane-shifted write data and read/write enables.
- Aligns and extends returned read data; splits misaligned halfword/word accesses into two word accesses.

Parameters:
- ADDR_WIDTH, 14, byte-address width; memory word address is ADDR_WIDTH-2 bits.
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = reject them with resp_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 giving size and sign.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: illegal funct3 or rejected misalignment.
- resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- busy  out  1  high whenever state != IDLE; used as core stall.
- mem_addr  out  ADDR_WIDTH-2  word address.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_byte_sel  out  4  lane select, bit i = bits [8i+7:8i].
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. Every output is 0 except req_ready, which is 1.
- Reset mid-operation: the access is abandoned with no resp_valid. A first-half store that is already written stays written; there is no rollback.
- Clocking and outputs: all mem_* and resp_* outputs are registered. mem_we, mem_re and mem_byte_sel are 0 outside the ACC states.
- Handshake:
  - req_ready = (state == IDLE).
  - A request is accepted on a rising edge with req_valid & req_ready; request fields are latched at that edge.
  - resp has no backpressure.
  - The next accept is possible the cycle after DONE.
- Decode:
  - off = req_addr[1:0]; word = req_addr[ADDR_WIDTH-1:2].
  - Sizes: funct3[1:0] = 00 byte (mask 0001), 01 half (0011), 10 word (1111).
  - funct3 011, 110, 111 are illegal.
  - funct3 111 with req_we = 1 is also illegal, and so are stores with funct3[2] = 1.
  - Misaligned = (mask << off) spills above bit 3.
- Lane mapping:
  - First access: sel0 = (mask << off)[3:0], wdata0 = req_wdata << 8*off, addr0 = word.
  - Second access: sel1 = (mask << off)[7:4], wdata1 = req_wdata >> 8*(4-off), addr1 = word + 1.
  - addr1 wraps modulo 2^(ADDR_WIDTH-2), so max word + 1 = 0.
- States:
  - IDLE: on accept, go to ERR if illegal, or misaligned with ALLOW_MISALIGNED = 0; otherwise go to ACC0 and drive addr0/sel0/wdata0 with we or re.
  - ACC0: store aligned → DONE; store misaligned → ACC1 (drive addr1/sel1/wdata1); load → CAP0.
  - CAP0: latch mem_rdata into lo. Aligned → DONE; misaligned → ACC1 with re.
  - ACC1: store → DONE; load → CAP1.
  - CAP1: latch mem_rdata into hi, then → DONE.
  - DONE: resp_valid = 1 for one cycle, then → IDLE.
  - ERR: resp_valid = 1 and resp_err = 1 for one cycle; no memory access; then → IDLE.
- Latency (accept edge to resp_valid high):
  - aligned store: 2 cycles;
  - aligned load: 3 cycles;
  - misaligned store: 3 cycles;
  - misaligned load: 5 cycles;
  - error: 1 cycle.
- Read assembly:
  - raw = ({hi, lo} >> 8*off)[31:0]. Lanes not selected are don't-care from memory and must be masked by size before extension.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - When aligned, hi is treated as 0.
- Stores: resp_rdata = 0.

Test Plan:
- Reset: hold rst_n = 0 mid misaligned load → all outputs 0, req_ready = 1, no resp_valid after release.
- SW 0xDEADBEEF @0x10, then LW @0x10:
  - store: mem_addr = 4, sel = 1111, we pulsed 1 cycle.
  - load: resp_rdata = 0xDEADBEEF, 3 cycles after accept.
- Byte loads and stores:
  - SB 0x80 @0x23 → sel = 1000, mem_wdata[31:24] = 0x80.
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x23 → 0x00000080.
- Misaligned store SW 0x11223344 @0x06:
  - first access: addr 1, sel 1100, wdata 0x33440000;
  - second access: addr 2, sel 0011, wdata 0x00001122.
  - Then LW @0x06 → 0x11223344 after 5 cycles.
- Wrap and halfword split:
  - LH @ top address 2^ADDR_WIDTH−1 → second access addr 0, sel 0001.
  - Result is sign-extended {byte@0, byte@top}.
- Errors:
  - funct3 = 011 → resp_err = 1 one cycle after accept, mem_we = mem_re = 0 throughout.
  - With ALLOW_MISALIGNED = 0, LW @0x01 → same error behaviour.
